cpu_selftest_seq: RTL and testbench
===================================

Name: cpu_selftest_seq

Overview:
Synthesizable, parametrised self-checking stimulus engine; the hardware successor to the cpu_top directed bench. It holds a loadable table of test vectors (write data, ALU op, expected result, expected zero flag) and resets the CPU datapath. It then drives each vector, waits a fixed latency, compares alu_result and z_flag, and reports pass/fail counts. It sits beside cpu_top on FPGA builds and in regression benches; the bench only loads vectors, pulses start and reads status.

Parameters:
DATA_W, 32, datapath width of wdata/alu_result/expected value
OP_W, 7, ALU op field width
NUM_VEC, 16, vector table depth (power of two, >=2)
LATENCY, 2, cycles from vector drive to result sampling (>=1)
RST_CYC, 4, cycles dut_rst_n_o is held low before the run (>=1)

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_n_i  in  1  synchronous active-low reset
ld_en_i  in  1  write one vector table entry this cycle
ld_addr_i  in  $clog2(NUM_VEC)  table index
ld_wdata_i  in  DATA_W  stimulus write data
ld_op_i  in  OP_W  stimulus ALU op
ld_exp_i  in  DATA_W  expected alu_result
ld_expz_i  in  1  expected z_flag
run_len_i  in  $clog2(NUM_VEC)+1  number of vectors to run, sampled at start
start_i  in  1  start pulse
abort_i  in  1  abort current run
dut_rst_n_o  out  1  drives cpu_top rst_n_i
dut_wr_en_o  out  1  drives cpu_top wr_en_i
dut_wdata_o  out  DATA_W  drives cpu_top wdata_i
dut_alu_op_o  out  OP_W  drives cpu_top alu_op_i
dut_result_i  in  DATA_W  cpu_top alu_result_o
dut_zflag_i  in  1  cpu_top z_flag_o
busy_o  out  1  run in progress
done_o  out  1  one-cycle pulse at run end
pass_o  out  1  last run finished with zero mismatches
fail_cnt_o  out  $clog2(NUM_VEC)+1  mismatches in last run
first_fail_o  out  $clog2(NUM_VEC)  index of first mismatching vector

Behaviour:
- Reset (rst_n_i=0 at edge): state IDLE. dut_rst_n_o=0, dut_wr_en_o=0, dut_wdata_o=0, dut_alu_op_o=0, busy_o=0, done_o=0, pass_o=0, fail_cnt_o=0, first_fail_o=0. The table contents are not reset.
- Table: synchronous write when ld_en_i=1 and busy_o=0. The write is ignored while busy. Outputs are registered; table reads are combinational from the current index.
- FSM states: IDLE, DUT_RST, DRIVE, WAIT, CHECK, FINISH.
- IDLE: dut_rst_n_o=1, dut_wr_en_o=0. On start_i=1, latch run_len_i into len, clear fail_cnt/first_fail/pass, set idx=0 and busy_o=1, then go to DUT_RST. If the latched len=0 or len>NUM_VEC, go to FINISH instead with fail_cnt=0.
- DUT_RST: dut_rst_n_o=0 for exactly RST_CYC cycles, then DRIVE.
- DRIVE (1 cycle): dut_rst_n_o=1, dut_wr_en_o=1, dut_wdata_o/dut_alu_op_o=table[idx]. Go to WAIT. Drive values hold until the next DRIVE.
- WAIT: count LATENCY-1 cycles, then CHECK. With LATENCY=1, WAIT lasts 0 cycles, so DRIVE goes directly to CHECK.
- CHECK (1 cycle): a mismatch is dut_result_i!=exp[idx] or dut_zflag_i!=expz[idx].
  - On mismatch: fail_cnt+=1, saturating at NUM_VEC. If this is the first mismatch, first_fail=idx.
  - If idx==len-1, go to FINISH; otherwise idx+=1 and go to DRIVE.
- FINISH (1 cycle): done_o=1, pass_o=(fail_cnt==0), busy_o=0, dut_wr_en_o=0, then IDLE. Status outputs hold until the next start or reset.
- Result latency per vector is 1+LATENCY cycles. Total run length is RST_CYC + len*(1+LATENCY) + 1 cycles from start to done.
- start_i while busy is ignored.
- abort_i while busy, in any non-IDLE state: go to FINISH next cycle. pass_o=0 regardless of counts, and fail_cnt keeps its partial value. abort_i wins over a simultaneous CHECK result, which is discarded.
- Simultaneous start_i and abort_i in IDLE: start wins, abort is ignored.
- Reset mid-run returns to IDLE with all outputs at their reset values. The table persists.
- Index arithmetic is unsigned; idx never exceeds len-1.

Test Plan:
- Load 3 vectors matching a model DUT (result=wdata, z=(wdata==0)): {0x00FF00FF,op 4}, {0,op 9}, {0xDEADBEEF,op 0}. Set run_len=3 and start → done_o pulse at cycle RST_CYC+3*(1+LATENCY)+1, pass_o=1, fail_cnt_o=0.
- Same table with exp[1] set to 0x1 → pass_o=0, fail_cnt_o=1, first_fail_o=1.
- Mismatch on z_flag only (vector 2 expz=1) → fail_cnt_o=1, first_fail_o=2. Check dut_rst_n_o is low exactly RST_CYC cycles after start.
- run_len=0 → done_o 1 cycle after start, pass_o=1, dut_wr_en_o never high. run_len=NUM_VEC+1 → same immediate finish.
- abort_i during WAIT of vector 1 → done_o next cycle, pass_o=0. ld_en_i and start_i pulses during the run have no effect: the table read back on a second run is unchanged.
- rst_n_i low during DRIVE → all outputs at reset values next cycle. A following start with the old table produces the same pass result.

Source files
------------

// File: rtl/cpu_selftest_seq.sv
// Self-checking stimulus engine for cpu_top: resets the datapath, replays a
// loadable vector table, compares result/zero flag and reports pass/fail counts.
module cpu_selftest_seq #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 7,
  parameter int NUM_VEC = 16,
  parameter int LATENCY = 2,
  parameter int RST_CYC = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         ld_en_i,
  input  logic [$clog2(NUM_VEC)-1:0]   ld_addr_i,
  input  logic [DATA_W-1:0]            ld_wdata_i,
  input  logic [OP_W-1:0]              ld_op_i,
  input  logic [DATA_W-1:0]            ld_exp_i,
  input  logic                         ld_expz_i,
  input  logic [$clog2(NUM_VEC):0]     run_len_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  output logic                         dut_rst_n_o,
  output logic                         dut_wr_en_o,
  output logic [DATA_W-1:0]            dut_wdata_o,
  output logic [OP_W-1:0]              dut_alu_op_o,
  input  logic [DATA_W-1:0]            dut_result_i,
  input  logic                         dut_zflag_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic [$clog2(NUM_VEC):0]     fail_cnt_o,
  output logic [$clog2(NUM_VEC)-1:0]   first_fail_o
);
  localparam int AW  = $clog2(NUM_VEC);
  localparam int LW  = AW + 1;
  localparam int WCW = $clog2(LATENCY) + 1;
  localparam int RCW = $clog2(RST_CYC) + 1;

  typedef enum logic [2:0] {IDLE, DUT_RST, DRIVE, WAIT, CHECK, FINISH} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] exp;
    logic              expz;
  } vec_t;

  vec_t tbl [NUM_VEC];

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d, first_fail_q, first_fail_d;
  logic [LW-1:0]     len_q, len_d, fail_cnt_q, fail_cnt_d;
  logic [RCW-1:0]    rcnt_q, rcnt_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic              aborted_q, aborted_d, pass_q, pass_d;
  logic              busy_q, done_q, dut_rst_n_q, dut_wr_en_q;
  logic [DATA_W-1:0] dut_wdata_q;
  logic [OP_W-1:0]   dut_op_q;
  logic              mismatch, last;

  // Table is deliberately not reset so a datapath reset keeps the loaded vectors.
  always_ff @(posedge clk_i) begin
    if (ld_en_i && !busy_q)
      tbl[ld_addr_i] <= '{wdata: ld_wdata_i, op: ld_op_i, exp: ld_exp_i, expz: ld_expz_i};
  end

  assign mismatch = (dut_result_i != tbl[idx_q].exp) || (dut_zflag_i != tbl[idx_q].expz);
  assign last     = ({1'b0, idx_q} == len_q - LW'(1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    rcnt_d       = rcnt_q;
    wcnt_d       = wcnt_q;
    aborted_d    = aborted_q;
    pass_d       = pass_q;
    case (state_q)
      IDLE: if (start_i) begin
        len_d        = run_len_i;
        fail_cnt_d   = '0;
        first_fail_d = '0;
        pass_d       = 1'b0;
        idx_d        = '0;
        aborted_d    = 1'b0;
        rcnt_d       = RCW'(RST_CYC - 1);
        if (run_len_i == '0 || run_len_i > LW'(NUM_VEC)) state_d = FINISH;
        else                                             state_d = DUT_RST;
      end
      DUT_RST: if (rcnt_q == '0) state_d = DRIVE;
               else              rcnt_d  = rcnt_q - RCW'(1);
      DRIVE: begin
        wcnt_d  = WCW'(LATENCY - 1);
        state_d = (LATENCY == 1) ? CHECK : WAIT;
      end
      WAIT: if (wcnt_q <= WCW'(1)) state_d = CHECK;
            else                   wcnt_d  = wcnt_q - WCW'(1);
      CHECK: begin
        if (mismatch) begin
          if (fail_cnt_q == '0)          first_fail_d = idx_q;
          if (fail_cnt_q != LW'(NUM_VEC)) fail_cnt_d  = fail_cnt_q + LW'(1);
        end
        if (last) state_d = FINISH;
        else begin
          idx_d   = idx_q + AW'(1);
          state_d = DRIVE;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort discards any result being checked this cycle.
    if (busy_q && abort_i) begin
      state_d      = FINISH;
      idx_d        = idx_q;
      fail_cnt_d   = fail_cnt_q;
      first_fail_d = first_fail_q;
      aborted_d    = 1'b1;
    end
    if (state_d == FINISH) pass_d = !aborted_d && (fail_cnt_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      rcnt_q       <= '0;
      wcnt_q       <= '0;
      aborted_q    <= 1'b0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dut_rst_n_q  <= 1'b0;
      dut_wr_en_q  <= 1'b0;
      dut_wdata_q  <= '0;
      dut_op_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      rcnt_q       <= rcnt_d;
      wcnt_q       <= wcnt_d;
      aborted_q    <= aborted_d;
      pass_q       <= pass_d;
      busy_q       <= (state_d == DUT_RST) || (state_d == DRIVE) ||
                      (state_d == WAIT)    || (state_d == CHECK);
      done_q       <= (state_d == FINISH);
      dut_rst_n_q  <= (state_d != DUT_RST);
      dut_wr_en_q  <= (state_d == DRIVE);
      if (state_d == DRIVE) begin
        dut_wdata_q <= tbl[idx_d].wdata;
        dut_op_q    <= tbl[idx_d].op;
      end
    end
  end

  assign dut_rst_n_o  = dut_rst_n_q;
  assign dut_wr_en_o  = dut_wr_en_q;
  assign dut_wdata_o  = dut_wdata_q;
  assign dut_alu_op_o = dut_op_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign fail_cnt_o   = fail_cnt_q;
  assign first_fail_o = first_fail_q;
endmodule

// File: tb/tb_cpu_selftest_seq.sv
// Bench for cpu_selftest_seq: a pass-through datapath model answers the
// engine, and a scoreboard queue holds the expected run outcome of each start.
module tb_cpu_selftest_seq;
  localparam int DATA_W = 32, OP_W = 7, NUM_VEC = 16, LATENCY = 2, RST_CYC = 4;
  localparam int AW = $clog2(NUM_VEC);
  localparam int LW = AW + 1;

  logic              clk = 0, rst_n = 0;
  logic              ld_en = 0, ld_expz = 0, start = 0, abort = 0;
  logic [AW-1:0]     ld_addr = '0;
  logic [DATA_W-1:0] ld_wdata = '0, ld_exp = '0;
  logic [OP_W-1:0]   ld_op = '0;
  logic [LW-1:0]     run_len = '0;
  logic              dut_rst_n, dut_wr_en, dut_zflag;
  logic [DATA_W-1:0] dut_wdata, dut_result;
  logic [OP_W-1:0]   dut_alu_op;
  logic              busy, done, pass;
  logic [LW-1:0]     fail_cnt;
  logic [AW-1:0]     first_fail;

  int checks = 0, errors = 0;
  int rst_low_cnt = 0, wr_cnt = 0;
  logic [OP_W-1:0] ops [$];

  typedef struct { int lat; bit pass; int fc; int ff; } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  cpu_selftest_seq #(.DATA_W(DATA_W), .OP_W(OP_W), .NUM_VEC(NUM_VEC),
                     .LATENCY(LATENCY), .RST_CYC(RST_CYC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ld_en_i(ld_en), .ld_addr_i(ld_addr),
    .ld_wdata_i(ld_wdata), .ld_op_i(ld_op), .ld_exp_i(ld_exp), .ld_expz_i(ld_expz),
    .run_len_i(run_len), .start_i(start), .abort_i(abort),
    .dut_rst_n_o(dut_rst_n), .dut_wr_en_o(dut_wr_en), .dut_wdata_o(dut_wdata),
    .dut_alu_op_o(dut_alu_op), .dut_result_i(dut_result), .dut_zflag_i(dut_zflag),
    .busy_o(busy), .done_o(done), .pass_o(pass), .fail_cnt_o(fail_cnt),
    .first_fail_o(first_fail));

  // Datapath model: result = last written data, z = (data == 0)
  always @(posedge clk) begin
    if (!dut_rst_n) begin dut_result <= '0; dut_zflag <= 1'b1; end
    else if (dut_wr_en) begin dut_result <= dut_wdata; dut_zflag <= (dut_wdata == '0); end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!dut_rst_n) rst_low_cnt++;
      if (dut_wr_en) begin wr_cnt++; ops.push_back(dut_alu_op); end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int run_lat(input int len);
    return RST_CYC + len * (1 + LATENCY) + 1;
  endfunction

  task automatic load(input int a, input logic [DATA_W-1:0] wd, input logic [OP_W-1:0] op,
                      input logic [DATA_W-1:0] ex, input logic ez);
    @(negedge clk);
    ld_en = 1; ld_addr = AW'(a); ld_wdata = wd; ld_op = op; ld_exp = ex; ld_expz = ez;
    @(negedge clk);
    ld_en = 0;
  endtask

  task automatic load_base();
    load(0, 32'h00FF00FF, 7'd4, 32'h00FF00FF, 1'b0);
    load(1, 32'h0,        7'd9, 32'h0,        1'b1);
    load(2, 32'hDEADBEEF, 7'd0, 32'hDEADBEEF, 1'b0);
  endtask

  // Pulses start and waits (bounded) for done; lat counts cycles from the start cycle.
  task automatic do_run(input logic [LW-1:0] len, output int lat, output bit to);
    int n;
    @(negedge clk);
    run_len = len; start = 1; rst_low_cnt = 0; wr_cnt = 0; ops.delete();
    @(negedge clk);
    start = 0; n = 1;
    while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    lat = n; to = (n >= 400);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, pass, fail_cnt, first_fail} !== '0) begin errors++;
      $display("FAIL reset_status: got busy%b done%b pass%b fc%0d ff%0d want all 0", busy, done, pass, fail_cnt, first_fail); end
    checks++; if ({dut_rst_n, dut_wr_en, dut_wdata, dut_alu_op} !== '0) begin errors++;
      $display("FAIL reset_drive: got rst_n%b wr%b wd%h op%h want all 0", dut_rst_n, dut_wr_en, dut_wdata, dut_alu_op); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (dut_rst_n !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL idle_after_reset: got dut_rst_n %b busy %b want 1 0", dut_rst_n, busy); end
  endtask

  task automatic test_pass();
    int lat; bit to; exp_t e;
    logic [OP_W-1:0] exp_ops [$];
    exp_ops = '{7'd4, 7'd9, 7'd0};
    load_base();
    sb.push_back('{run_lat(3), 1'b1, 0, 0});
    do_run(LW'(3), lat, to);
    e = sb.pop_front();
    checks++; if (to || lat != e.lat) begin errors++; $display("FAIL pass_latency: got %0d want %0d", lat, e.lat); end
    checks++; if (pass !== e.pass || fail_cnt !== LW'(e.fc)) begin errors++;
      $display("FAIL pass_status: got pass %b fc %0d want %b %0d", pass, fail_cnt, e.pass, e.fc); end
    checks++; if (wr_cnt != 3 || ops != exp_ops) begin errors++;
      $display("FAIL pass_drives: got %0d writes ops %p want 3 writes %p", wr_cnt, ops, exp_ops); end
    checks++; if (rst_low_cnt != RST_CYC) begin errors++;
      $display("FAIL pass_rst_len: got %0d want %0d", rst_low_cnt, RST_CYC); end
  endtask

  task automatic test_result_mismatch();
    int lat; bit to; exp_t e;
    load(1, 32'h0, 7'd9, 32'h1, 1'b1);
    sb.push_back('{run_lat(3), 1'b0, 1, 1});
    do_run(LW'(3), lat, to);
    e = sb.pop_front();
    checks++; if (to || lat != e.lat) begin errors++; $display("FAIL mism_latency: got %0d want %0d", lat, e.lat); end
    checks++; if (pass !== e.pass || fail_cnt !== LW'(e.fc) || first_fail !== AW'(e.ff)) begin errors++;
      $display("FAIL mism_status: got pass %b fc %0d ff %0d want %b %0d %0d", pass, fail_cnt, first_fail, e.pass, e.fc, e.ff); end
    load(1, 32'h0, 7'd9, 32'h0, 1'b1);
  endtask

  task automatic test_zflag_mismatch();
    int lat; bit to; exp_t e;
    load(2, 32'hDEADBEEF, 7'd0, 32'hDEADBEEF, 1'b1);
    sb.push_back('{run_lat(3), 1'b0, 1, 2});
    do_run(LW'(3), lat, to);
    e = sb.pop_front();
    checks++; if (to || pass !== e.pass || fail_cnt !== LW'(e.fc) || first_fail !== AW'(e.ff)) begin errors++;
      $display("FAIL zflag_status: got to %b pass %b fc %0d ff %0d want 0 %b %0d %0d", to, pass, fail_cnt, first_fail, e.pass, e.fc, e.ff); end
    checks++; if (rst_low_cnt != RST_CYC) begin errors++;
      $display("FAIL zflag_rst_len: got %0d want %0d", rst_low_cnt, RST_CYC); end
    load(2, 32'hDEADBEEF, 7'd0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_len_bounds();
    int lat; bit to; exp_t e;
    logic [LW-1:0] lens [2];
    lens[0] = '0; lens[1] = LW'(NUM_VEC + 1);
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1, 1'b1, 0, 0});
      do_run(lens[i], lat, to);
      e = sb.pop_front();
      checks++; if (to || lat != e.lat || pass !== e.pass || fail_cnt !== LW'(e.fc)) begin errors++;
        $display("FAIL len_bound_%0d: got lat %0d pass %b fc %0d want %0d %b %0d", lens[i], lat, pass, fail_cnt, e.lat, e.pass, e.fc); end
      @(negedge clk);
      checks++; if (wr_cnt != 0 || rst_low_cnt != 0) begin errors++;
        $display("FAIL len_bound_drive_%0d: got %0d writes %0d rst cycles want 0 0", lens[i], wr_cnt, rst_low_cnt); end
    end
  endtask

  task automatic test_abort();
    int n, lat; bit to; exp_t e;
    sb.push_back('{10, 1'b0, 0, 0});
    @(negedge clk);
    run_len = LW'(3); start = 1;
    @(negedge clk);
    start = 0; n = 1;
    while (n < 9) begin
      if (n == 3) begin ld_en = 1; ld_addr = AW'(1); ld_wdata = 32'h1234; ld_exp = 32'hBAD; ld_expz = 0; end
      if (n == 5) begin start = 1; run_len = LW'(1); end
      @(negedge clk);
      ld_en = 0; start = 0; n++;
    end
    abort = 1;
    @(negedge clk);
    abort = 0; n++;
    e = sb.pop_front();
    checks++; if (done !== 1'b1 || n != e.lat) begin errors++;
      $display("FAIL abort_done: got done %b at cycle %0d want 1 at %0d", done, n, e.lat); end
    checks++; if (pass !== e.pass || fail_cnt !== LW'(e.fc) || busy !== 1'b0) begin errors++;
      $display("FAIL abort_status: got pass %b fc %0d busy %b want %b %0d 0", pass, fail_cnt, busy, e.pass, e.fc); end
    sb.push_back('{run_lat(3), 1'b1, 0, 0});
    do_run(LW'(3), lat, to);
    e = sb.pop_front();
    checks++; if (to || lat != e.lat || pass !== e.pass || fail_cnt !== LW'(e.fc)) begin errors++;
      $display("FAIL table_unchanged: got lat %0d pass %b fc %0d want %0d %b %0d", lat, pass, fail_cnt, e.lat, e.pass, e.fc); end
  endtask

  task automatic test_reset_midrun();
    int lat; bit to; exp_t e;
    @(negedge clk);
    run_len = LW'(3); start = 1;
    @(negedge clk);
    start = 0;
    repeat (RST_CYC) @(negedge clk);
    checks++; if (dut_wr_en !== 1'b1) begin errors++;
      $display("FAIL midrun_drive: got wr_en %b want 1", dut_wr_en); end
    rst_n = 0;
    @(negedge clk);
    checks++; if ({busy, done, pass, fail_cnt, first_fail, dut_rst_n, dut_wr_en, dut_wdata, dut_alu_op} !== '0) begin errors++;
      $display("FAIL midrun_reset: got busy%b done%b pass%b fc%0d rst_n%b wr%b wd%h want all 0", busy, done, pass, fail_cnt, dut_rst_n, dut_wr_en, dut_wdata); end
    rst_n = 1;
    @(negedge clk);
    sb.push_back('{run_lat(3), 1'b1, 0, 0});
    do_run(LW'(3), lat, to);
    e = sb.pop_front();
    checks++; if (to || lat != e.lat || pass !== e.pass || fail_cnt !== LW'(e.fc)) begin errors++;
      $display("FAIL rerun_after_reset: got lat %0d pass %b fc %0d want %0d %b %0d", lat, pass, fail_cnt, e.lat, e.pass, e.fc); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_result_mismatch();
    test_zflag_mismatch();
    test_len_bounds();
    test_abort();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
